// File: rtl/cpu_trace_pkg.sv
// Shared types and width helpers for the CPU instruction trace buffer.
package cpu_trace_pkg;

    // Capture/readout FSM encoding
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Pointer width for a power-of-two depth; never narrower than one bit
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width; must be able to represent depth itself
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram
    import cpu_trace_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_we,
    input  logic [ptr_width(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic [ptr_width(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]            o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the retired sample into its slot
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction trace buffer: pre-trigger ring capture, POST_CNT post-trigger
// samples, then oldest-first ready/valid readout.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned POST_CNT = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic [ADDR_W-1:0]           i_pc,
    input  logic [DATA_W-1:0]           i_instr,
    input  logic                        i_arm,
    input  logic [ADDR_W-1:0]           i_trig_pc,
    input  logic                        i_rd_ready,
    output logic                        o_rd_valid,
    output logic [ADDR_W-1:0]           o_rd_pc,
    output logic [DATA_W-1:0]           o_rd_instr,
    output logic [cnt_width(DEPTH)-1:0] o_count,
    output logic                        o_busy,
    output logic                        o_overflow
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    state_e             r_state, w_state_d;
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_d;
    logic [CNT_W-1:0]   r_count, w_count_d;
    logic [PTR_W-1:0]   r_post, w_post_d;
    logic               r_ovf, w_ovf_d;

    logic               w_capture;
    logic               w_full;
    logic               w_pop;
    logic [PTR_W-1:0]   w_rd_idx;
    logic [ENT_W-1:0]   w_rd_data;

    // arm wins over any sample taken in the same cycle
    assign w_capture  = (r_state == StArmed || r_state == StPost) && i_en && !i_arm;
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_pop      = o_rd_valid && i_rd_ready;
    // count==DEPTH truncates to 0, so a full ring reads from wr_ptr itself
    assign w_rd_idx   = r_wr_ptr - r_count[PTR_W-1:0];

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and datapath update for pointers, counters and overflow
    always_comb begin
        w_state_d  = r_state;
        w_wr_ptr_d = r_wr_ptr;
        w_count_d  = r_count;
        w_post_d   = r_post;
        w_ovf_d    = r_ovf;
        if (i_arm) begin
            w_state_d = StArmed;
            w_count_d = '0;
            w_post_d  = '0;
            w_ovf_d   = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                end
                StArmed: begin
                    if (i_en && (i_pc == i_trig_pc)) begin
                        if (POST_CNT == 0) begin
                            w_state_d = StDone;
                        end else begin
                            w_state_d = StPost;
                            w_post_d  = PTR_W'(POST_CNT);
                        end
                    end
                end
                StPost: begin
                    if (i_en) begin
                        w_post_d = r_post - PTR_W'(1);
                        if (r_post == PTR_W'(1)) begin
                            w_state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (w_pop) begin
                        w_count_d = r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            w_state_d = StIdle;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
            if (w_capture) begin
                w_wr_ptr_d = r_wr_ptr + PTR_W'(1);
                if (w_full) begin
                    w_ovf_d = 1'b1;
                end else begin
                    w_count_d = r_count + CNT_W'(1);
                end
            end
        end
    end

    // Pointer, counter and overflow registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_post   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_count  <= w_count_d;
            r_post   <= w_post_d;
            r_ovf    <= w_ovf_d;
        end
    end

    trace_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_trace_ram (
        .i_clk   (i_clk),
        .i_we    (w_capture),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_pc, i_instr}),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    assign o_rd_valid = (r_state == StDone) && (r_count != '0);
    assign o_rd_pc    = o_rd_valid ? w_rd_data[ENT_W-1 -: ADDR_W] : '0;
    assign o_rd_instr = o_rd_valid ? w_rd_data[DATA_W-1:0] : '0;
    assign o_count    = r_count;
    assign o_busy     = (r_state == StArmed) || (r_state == StPost);
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer (DEPTH=8, POST_CNT=3 and POST_CNT=0).
module tb_cpu_trace_buffer;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned POST  = 3;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, arm, rdy0, rdy1;
    logic [AW-1:0] pc, trig_pc;
    logic [DW-1:0] instr;

    logic          v0, busy0, ovf0;
    logic [AW-1:0] rpc0;
    logic [DW-1:0] rins0;
    logic [CW-1:0] cnt0;
    logic          v1, busy1, ovf1;
    logic [AW-1:0] rpc1;
    logic [DW-1:0] rins1;
    logic [CW-1:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of expected readout pcs for dut0, plus a spec-level capture model
    logic [AW-1:0] sb[$];
    int            m_state;   // 0 idle, 1 armed, 2 post, 3 done
    int            m_post;
    logic [AW-1:0] m_trig;

    typedef struct {
        logic [AW-1:0] trig;
        logic [AW-1:0] first;
        int            n;
        int            cnt;
        logic          ovf;
        logic [AW-1:0] oldest;
    } vec_t;
    vec_t vec[5];

    always #5 clk = ~clk;

    cpu_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .POST_CNT(POST)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pc(pc), .i_instr(instr), .i_arm(arm),
        .i_trig_pc(trig_pc), .i_rd_ready(rdy0), .o_rd_valid(v0), .o_rd_pc(rpc0),
        .o_rd_instr(rins0), .o_count(cnt0), .o_busy(busy0), .o_overflow(ovf0)
    );

    cpu_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .POST_CNT(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pc(pc), .i_instr(instr), .i_arm(arm),
        .i_trig_pc(trig_pc), .i_rd_ready(rdy1), .o_rd_valid(v1), .o_rd_pc(rpc1),
        .o_rd_instr(rins1), .o_count(cnt1), .o_busy(busy1), .o_overflow(ovf1)
    );

    function automatic logic [DW-1:0] f_instr(input logic [AW-1:0] p);
        return p ^ 16'hC3A5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arm with a non-matching sample on en to show it is discarded
    task automatic do_arm(input logic [AW-1:0] trig);
        arm = 1'b1; trig_pc = trig; en = 1'b1; pc = 16'hFFFF; instr = f_instr(16'hFFFF);
        tick();
        arm = 1'b0; en = 1'b0;
        sb.delete();
        m_state = 1; m_post = 0; m_trig = trig;
        chk("arm_count", 32'(cnt0), 32'd0);
        chk("arm_busy", 32'(busy0), 32'd1);
        chk("arm_valid", 32'(v0), 32'd0);
    endtask

    task automatic send(input logic [AW-1:0] p);
        en = 1'b1; pc = p; instr = f_instr(p);
        if (m_state == 1 || m_state == 2) begin
            sb.push_back(p);
            if (sb.size() > DEPTH) void'(sb.pop_front());
            if (m_state == 1 && p == m_trig) begin
                m_state = 2; m_post = POST;
            end else if (m_state == 2) begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end
        tick();
        en = 1'b0;
    endtask

    // Pop up to max_pops entries from dut0, stalling stall_len cycles after stall_at pops
    task automatic drain(input int stall_at, input int stall_len, input int max_pops);
        int budget = 4 * DEPTH + 20;
        int popped = 0;
        int stalled = 0;
        while (sb.size() != 0 && popped < max_pops && budget > 0) begin
            budget--;
            chk("rd_valid", 32'(v0), 32'd1);
            chk("rd_pc", 32'(rpc0), 32'(sb[0]));
            chk("rd_count", 32'(cnt0), 32'(sb.size()));
            if (popped == stall_at && stalled < stall_len) begin
                rdy0 = 1'b0;
                stalled++;
            end else begin
                rdy0 = 1'b1;
                chk("rd_instr", 32'(rins0), 32'(f_instr(sb[0])));
                void'(sb.pop_front());
                popped++;
            end
            tick();
        end
        rdy0 = 1'b0;
        if (budget == 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: got %0d left, expected 0", sb.size());
        end
        if (sb.size() == 0 && m_state == 3) m_state = 0;
    endtask

    initial begin
        vec[0] = '{16'd2,    16'd0,    6,  6, 1'b0, 16'd0};
        vec[1] = '{16'd12,   16'd0,    16, 8, 1'b1, 16'd8};
        vec[2] = '{16'd7,    16'd0,    11, 8, 1'b1, 16'd3};
        vec[3] = '{16'h0040, 16'h0040, 4,  4, 1'b0, 16'h0040};
        vec[4] = '{16'd5,    16'd0,    10, 8, 1'b1, 16'd1};  // last pc arrives in DONE

        rst_n = 1'b0; en = 1'b0; arm = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
        pc = '0; instr = '0; trig_pc = '0; m_state = 0; m_post = 0; m_trig = '0;
        #12;
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_rd_pc", 32'(rpc0), 32'd0);
        chk("rst_rd_instr", 32'(rins0), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven captures with full readout
        for (int v = 0; v < 5; v++) begin
            do_arm(vec[v].trig);
            for (int k = 0; k < vec[v].n; k++) send(vec[v].first + AW'(k));
            chk("cap_count", 32'(cnt0), 32'(vec[v].cnt));
            chk("cap_ovf", 32'(ovf0), 32'(vec[v].ovf));
            chk("cap_busy", 32'(busy0), 32'd0);
            chk("cap_oldest", 32'(rpc0), 32'(vec[v].oldest));
            chk("cap_sb_size", 32'(sb.size()), 32'(vec[v].cnt));
            drain(-1, 0, 1000);
            chk("end_valid", 32'(v0), 32'd0);
            chk("end_count", 32'(cnt0), 32'd0);
            chk("end_rd_pc", 32'(rpc0), 32'd0);
            chk("end_ovf_hold", 32'(ovf0), 32'(vec[v].ovf));
            send(16'h0077);  // en in IDLE must be ignored
            chk("idle_ignore", 32'(cnt0), 32'd0);
        end

        // Readout stall: rd_ready low for 3 cycles after the first pop
        do_arm(16'd2);
        for (int k = 0; k < 6; k++) send(AW'(k));
        drain(1, 3, 1000);
        chk("stall_end_valid", 32'(v0), 32'd0);

        // Reset in the middle of POST
        do_arm(16'd2);
        for (int k = 0; k < 4; k++) send(AW'(k));
        chk("post_busy", 32'(busy0), 32'd1);
        chk("post_count", 32'(cnt0), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(cnt0), 32'd0);
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_valid", 32'(v0), 32'd0);
        tick();
        rst_n = 1'b1;
        sb.delete(); m_state = 0;
        send(16'd4);
        send(16'd2);
        chk("after_rst_count", 32'(cnt0), 32'd0);
        chk("after_rst_valid", 32'(v0), 32'd0);

        // POST_CNT=0 instance: trigger sample ends the capture
        do_arm(16'd3);
        for (int k = 0; k < 4; k++) send(AW'(k));
        chk("p0_valid", 32'(v1), 32'd1);
        chk("p0_count", 32'(cnt1), 32'd4);
        chk("p0_busy", 32'(busy1), 32'd0);
        chk("p0_ovf", 32'(ovf1), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("p0_rd_pc", 32'(rpc1), 32'(k));
            chk("p0_rd_instr", 32'(rins1), 32'(f_instr(AW'(k))));
            rdy1 = 1'b1;
            tick();
        end
        rdy1 = 1'b0;
        chk("p0_end_valid", 32'(v1), 32'd0);
        chk("p0_end_count", 32'(cnt1), 32'd0);

        // Re-arm during DONE after two pops
        do_arm(16'd2);
        for (int k = 0; k < 6; k++) send(AW'(k));
        drain(-1, 0, 2);
        chk("done_count_after2", 32'(cnt0), 32'd4);
        do_arm(16'd20);
        for (int k = 0; k < 4; k++) send(AW'(20 + k));
        chk("rearm_count", 32'(cnt0), 32'd4);
        chk("rearm_ovf", 32'(ovf0), 32'd0);
        drain(-1, 0, 1000);
        chk("rearm_end_valid", 32'(v0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter ADDR_W, default 16, meaning: instruction address width.
REQ-002 Parameter DATA_W, default 16, meaning: instruction word width.
REQ-003 Parameter DEPTH, default 16, meaning: trace entries; power of two, at least 2.
REQ-004 Parameter POST_CNT, default 4, meaning: samples captured after the trigger sample; range 0..DEPTH-1.
REQ-005 Port clk, input, 1, meaning: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, meaning: asynchronous, active-low reset.
REQ-007 Port en, input, 1, meaning: instruction retire strobe; sample pc/instr this cycle.
REQ-008 Port pc, input, ADDR_W, meaning: retired instruction address.
REQ-009 Port instr, input, DATA_W, meaning: retired instruction word.
REQ-010 Port arm, input, 1, meaning: clear buffer and start pre-trigger capture.
REQ-011 Port trig_pc, input, ADDR_W, meaning: trigger address.
REQ-012 Port rd_ready, input, 1, meaning: consumer accepts the current readout entry.
REQ-013 Port rd_valid, output, 1, meaning: readout entry available.
REQ-014 Port rd_pc, output, ADDR_W, meaning: readout address.
REQ-015 Port rd_instr, output, DATA_W, meaning: readout instruction word.
REQ-016 Port count, output, clog2(DEPTH+1), meaning: entries held.
REQ-017 Port busy, output, 1, meaning: state is ARMED or POST.
REQ-018 Port overflow, output, 1, meaning: at least one oldest entry overwritten since arm.

Function
REQ-019 The FSM SHALL have four states: IDLE, ARMED, POST, DONE.
REQ-020 In any state, arm SHALL clear count, overflow and the post counter, and enter ARMED; arm has priority, and that cycle's sample is discarded.
REQ-021 In IDLE, en SHALL be ignored and no trigger SHALL be evaluated.
REQ-022 In ARMED, each en cycle SHALL write {pc,instr} at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-023 count SHALL saturate at DEPTH; a write while count==DEPTH SHALL overwrite the oldest entry and set overflow.
REQ-024 In ARMED, en with pc==trig_pc SHALL record the sample and enter POST with the post counter loaded to POST_CNT; if POST_CNT==0, it SHALL enter DONE instead.
REQ-025 In POST, each en cycle SHALL record the sample and decrement the post counter; recording the sample that brings the counter to 0 SHALL enter DONE; pc matches SHALL be ignored.
REQ-026 In POST, cycles with en low SHALL neither record nor decrement.
REQ-027 In DONE, capture SHALL stop.
REQ-028 rd_valid SHALL equal (state==DONE && count!=0), combinationally.
REQ-029 The readout entry SHALL be the oldest entry, at index (wr_ptr-count) mod DEPTH.
REQ-030 rd_pc and rd_instr SHALL be valid in the same cycle as rd_valid, and SHALL be 0 when rd_valid is low.
REQ-031 When rd_valid && rd_ready, count SHALL decrement at the clock edge; the next entry follows in the next cycle.
REQ-032 While rd_valid is high and rd_ready is low, rd_pc and rd_instr SHALL hold stable.
REQ-033 When the final entry is popped, the FSM SHALL enter IDLE; overflow SHALL hold until the next arm or reset.
REQ-034 Readout throughput SHALL be one entry per cycle.

Reset
REQ-035 Asserting rst (low) SHALL asynchronously force state=IDLE, count=0, wr_ptr=0, post counter=0 and overflow=0.
REQ-036 During reset, rd_valid, rd_pc, rd_instr and busy SHALL all be 0; RAM contents are not reset.
REQ-037 Reset asserted mid-POST or mid-readout SHALL discard the capture; no partial readout follows.

Structure
REQ-038 Package cpu_trace_pkg SHALL hold the FSM state encoding and the count/pointer width helper constants.
REQ-039 Storage SHALL be sub-module trace_ram: DEPTH x (ADDR_W+DATA_W), one synchronous write port, one asynchronous read port.
REQ-040 The FSM, pointers and counters SHALL reside in cpu_trace_buffer.

Verification
All scenarios use DEPTH=8, POST_CNT=3 unless stated.
REQ-041 Arm, trig_pc=2, en with pc=0..5 -> DONE after pc=5; count=6; readout pc 0,1,2,3,4,5; overflow=0.
REQ-042 Arm, trig_pc=12, pc=0..15 -> count=8; readout pc 8..15; overflow=1.
REQ-043 Readout with rd_ready low for 3 cycles -> rd_pc held at the same value, count unchanged; resumes correctly.
REQ-044 rst asserted mid-POST -> IDLE immediately, count=0, rd_valid=0, busy=0.
REQ-045 POST_CNT=0 instance, trigger at pc=3 after pc=0..2 -> DONE next cycle; count=4; last entry pc=3.
REQ-046 arm asserted during DONE after 2 pops -> count=0, ARMED, rd_valid=0; new capture proceeds normally.
